// File: rtl/nor_latch_extractor.sv
// nor_latch_extractor: buffers the NOR gates of a streamed NOR/NOT netlist,
// then scans every NOR pair (i < j, ascending) for cross-coupling and emits
// one SR-latch match record {s, r, q, p} per coupled pair.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. Once m_valid is raised, it and all m_* data stay stable until
// that transfer. in_ready is high only while loading.
// Internal FSM state is held in the 'state' signal for debug observation.
module nor_latch_extractor #(
    parameter int ID_W  = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_type,
    input  logic [ID_W-1:0]        in_a,
    input  logic [ID_W-1:0]        in_b,
    input  logic [ID_W-1:0]        in_y,
    input  logic                   in_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ID_W-1:0]        m_s,
    output logic [ID_W-1:0]        m_r,
    output logic [ID_W-1:0]        m_q,
    output logic [ID_W-1:0]        m_p,
    output logic                   done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] nor_count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] TWO     = CW'(2);

    typedef enum logic [1:0] {LOAD, SCAN, EMIT, FINISH} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   idx_i;
    logic [CW-1:0]   idx_j;
    logic [ID_W-1:0] tab_a [DEPTH];
    logic [ID_W-1:0] tab_b [DEPTH];
    logic [ID_W-1:0] tab_y [DEPTH];
    logic [DEPTH-1:0] used;

    logic [ID_W-1:0] a_i, b_i, y_i, a_j, b_j, y_j;
    logic [ID_W-1:0] pair_s, pair_r;
    logic            coupled, degenerate, last_j, scan_end, accept, store;
    logic [CW-1:0]   next_i, next_j, count_after;

    assign nor_count = count;

    // Pair evaluation for (idx_i, idx_j) and the next scan position.
    always_comb begin
        a_i        = tab_a[idx_i[IW-1:0]];
        b_i        = tab_b[idx_i[IW-1:0]];
        y_i        = tab_y[idx_i[IW-1:0]];
        a_j        = tab_a[idx_j[IW-1:0]];
        b_j        = tab_b[idx_j[IW-1:0]];
        y_j        = tab_y[idx_j[IW-1:0]];
        // A gate whose both inputs are the partner's output is not a latch half.
        degenerate = ((a_i == b_i) && (b_i == y_j)) || ((a_j == b_j) && (b_j == y_i));
        coupled    = ((y_i == a_j) || (y_i == b_j)) && ((y_j == a_i) || (y_j == b_i)) &&
                     !used[idx_i[IW-1:0]] && !used[idx_j[IW-1:0]] && !degenerate;
        // The set/reset input is the one not fed back; prefer A when both qualify.
        pair_s     = (a_i != y_j) ? a_i : b_i;
        pair_r     = (a_j != y_i) ? a_j : b_j;
        last_j     = ((idx_j + ONE) == count);
        next_i     = last_j ? (idx_i + ONE) : idx_i;
        next_j     = last_j ? (idx_i + TWO) : (idx_j + ONE);
        scan_end   = (next_i == (count - ONE));
        accept     = in_valid && in_ready;
        store      = accept && in_type && (count < DEPTH_C);
        count_after = store ? (count + ONE) : count;
    end

    // Load / scan / emit / finish sequencing with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            count    <= '0;
            idx_i    <= '0;
            idx_j    <= '0;
            used     <= '0;
            in_ready <= 1'b1;
            m_valid  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            m_s      <= '0;
            m_r      <= '0;
            m_q      <= '0;
            m_p      <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tab_a[k] <= '0;
                tab_b[k] <= '0;
                tab_y[k] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (store) begin
                            tab_a[count[IW-1:0]] <= in_a;
                            tab_b[count[IW-1:0]] <= in_b;
                            tab_y[count[IW-1:0]] <= in_y;
                            count <= count + ONE;
                        end else if (in_type) begin
                            overflow <= 1'b1;
                        end
                        if (in_last) begin
                            idx_i    <= '0;
                            idx_j    <= ONE;
                            in_ready <= 1'b0;
                            if (count_after < TWO) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                state <= SCAN;
                            end
                        end
                    end
                end
                SCAN: begin
                    idx_i <= next_i;
                    idx_j <= next_j;
                    if (coupled) begin
                        m_s <= pair_s;
                        m_r <= pair_r;
                        m_q <= y_j;
                        m_p <= y_i;
                        used[idx_i[IW-1:0]] <= 1'b1;
                        used[idx_j[IW-1:0]] <= 1'b1;
                        m_valid <= 1'b1;
                        state   <= EMIT;
                    end else if (scan_end) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        // Indices already point past the emitted pair.
                        if (idx_i == (count - ONE)) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                FINISH: begin
                    done     <= 1'b0;
                    count    <= '0;
                    used     <= '0;
                    overflow <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_nor_latch_extractor.sv
// Bench for nor_latch_extractor: directed vector table, backpressure, reset
// during emit, overflow, and randomized netlists against a pair-scan model.
module tb_nor_latch_extractor;
    localparam int ID_W  = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MW    = 4 * ID_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_type, in_last;
    logic [ID_W-1:0] in_a, in_b, in_y;
    logic            m_valid, m_ready;
    logic [ID_W-1:0] m_s, m_r, m_q, m_p;
    logic            done, overflow;
    logic [CW-1:0]   nor_count;

    // Clock generation.
    always #5 clk = ~clk;

    nor_latch_extractor #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_a(in_a), .in_b(in_b), .in_y(in_y), .in_last(in_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_s(m_s), .m_r(m_r), .m_q(m_q), .m_p(m_p),
        .done(done), .overflow(overflow), .nor_count(nor_count)
    );

    typedef struct packed {
        logic            is_nor;
        logic [ID_W-1:0] a;
        logic [ID_W-1:0] b;
        logic [ID_W-1:0] y;
    } rec_t;

    typedef struct packed {
        logic            is_nor;
        logic [ID_W-1:0] a;
        logic [ID_W-1:0] b;
        logic [ID_W-1:0] y;
        logic            last;
        logic [1:0]      n_exp;
        logic [MW-1:0]   exp0;
        logic [MW-1:0]   exp1;
    } vec_t;

    rec_t          cur_recs[$];
    logic [MW-1:0] exp_q[$];
    int            stall_mode;
    int            checks = 0;
    int            errors = 0;
    vec_t          vecs[14];

    function automatic logic [MW-1:0] pack_m(input logic [ID_W-1:0] s, r, q, p);
        return {s, r, q, p};
    endfunction

    function automatic rec_t mkrec(input logic is_nor, input logic [ID_W-1:0] a, b, y);
        rec_t t;
        t.is_nor = is_nor; t.a = a; t.b = b; t.y = y;
        return t;
    endfunction

    function automatic vec_t mk(input logic is_nor, input logic [ID_W-1:0] a, b, y,
                                input logic last, input logic [1:0] n_exp,
                                input logic [MW-1:0] e0, e1);
        vec_t v;
        v.is_nor = is_nor; v.a = a; v.b = b; v.y = y; v.last = last;
        v.n_exp = n_exp; v.exp0 = e0; v.exp1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: keep first DEPTH NORs in arrival order, try all pairs i<j ascending.
    task automatic model_matches();
        rec_t tab[$];
        bit   used_m[DEPTH];
        foreach (cur_recs[k])
            if (cur_recs[k].is_nor && tab.size() < DEPTH) tab.push_back(cur_recs[k]);
        for (int k = 0; k < DEPTH; k++) used_m[k] = 1'b0;
        for (int i = 0; i < tab.size(); i++) begin
            for (int j = i + 1; j < tab.size(); j++) begin
                rec_t gi;
                rec_t gj;
                bit   fb_ij, fb_ji, deg;
                logic [ID_W-1:0] s, r;
                gi = tab[i];
                gj = tab[j];
                fb_ij = (gi.y == gj.a) || (gi.y == gj.b);
                fb_ji = (gj.y == gi.a) || (gj.y == gi.b);
                deg = (gi.a == gj.y && gi.b == gj.y) || (gj.a == gi.y && gj.b == gi.y);
                if (!used_m[i] && !used_m[j] && fb_ij && fb_ji && !deg) begin
                    s = (gi.a == gj.y) ? gi.b : gi.a;
                    r = (gj.a == gi.y) ? gj.b : gj.a;
                    exp_q.push_back(pack_m(s, r, gj.y, gi.y));
                    used_m[i] = 1'b1;
                    used_m[j] = 1'b1;
                end
            end
        end
    endtask

    // Driver: push cur_recs through the input handshake; returns at the first
    // negedge after the last record was accepted.
    task automatic send_recs();
        for (int k = 0; k < cur_recs.size(); k++) begin
            int w;
            @(negedge clk);
            in_valid = 1'b1;
            in_type  = cur_recs[k].is_nor;
            in_a     = cur_recs[k].a;
            in_b     = cur_recs[k].b;
            in_y     = cur_recs[k].y;
            in_last  = (k == cur_recs.size() - 1);
            w = 0;
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("in_ready_wait", in_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Run one netlist: send, collect matches with planned stalls, check timing.
    task automatic run_cur();
        int n_nor, n_store, lat, mi, stall_left, n_exp;
        int stalls[$];
        bit holding, seen_done;
        logic [MW-1:0] held, got;
        n_nor = 0;
        foreach (cur_recs[k]) if (cur_recs[k].is_nor) n_nor++;
        n_store = (n_nor > DEPTH) ? DEPTH : n_nor;
        n_exp = exp_q.size();
        lat = n_store * (n_store - 1) / 2;
        for (int k = 0; k < n_exp; k++) begin
            int st;
            st = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
            stalls.push_back(st);
            lat += st + 1;
        end
        send_recs();
        // Offer a junk NOR while busy; it must not be taken.
        in_valid = 1'b1; in_type = 1'b1; in_a = 8'hEE; in_b = 8'hEF; in_y = 8'hF0; in_last = 1'b0;
        check("nor_count_loaded", nor_count, n_store);
        check("overflow_loaded", overflow, (n_nor > DEPTH));
        mi = 0; holding = 1'b0; seen_done = 1'b0; stall_left = 0; held = '0;
        for (int k = 1; k <= lat + 40; k++) begin
            if (k > 1) @(negedge clk);
            if (m_valid) begin
                if (!holding) begin
                    held = {m_s, m_r, m_q, m_p};
                    holding = 1'b1;
                    stall_left = (mi < n_exp) ? stalls[mi] : 0;
                end else begin
                    check("m_stable", {m_s, m_r, m_q, m_p}, held);
                end
                if (stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                end else begin
                    m_ready = 1'b1;
                    got = {m_s, m_r, m_q, m_p};
                    if (exp_q.size() == 0) check("match_count", mi + 1, n_exp);
                    else check("match", got, exp_q.pop_front());
                    mi++;
                    holding = 1'b0;
                end
            end else begin
                m_ready = 1'b0;
            end
            if (done) begin
                check("done_latency", k, lat + 1);
                seen_done = 1'b1;
                break;
            end
        end
        check("done_seen", seen_done, 1);
        @(negedge clk);
        m_ready  = 1'b0;
        in_valid = 1'b0;
        check("done_pulse", done, 0);
        check("ready_after", in_ready, 1);
        check("ovf_clear", overflow, 0);
        check("count_clear", nor_count, 0);
        check("missing_matches", exp_q.size(), 0);
        exp_q.delete();
        cur_recs.delete();
    endtask

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; in_type = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; in_y = '0; m_ready = 1'b0; stall_mode = 0;

        // Directed vector table: records with expected matches on the last one.
        vecs[0]  = mk(1, 1, 3, 2, 0, 0, '0, '0);
        vecs[1]  = mk(1, 2, 4, 3, 1, 1, pack_m(1, 4, 3, 2), '0);
        vecs[2]  = mk(1, 1, 2, 5, 0, 0, '0, '0);
        vecs[3]  = mk(0, 5, 0, 6, 0, 0, '0, '0);
        vecs[4]  = mk(1, 6, 3, 7, 1, 0, '0, '0);
        vecs[5]  = mk(1, 20, 30, 10, 0, 0, '0, '0);
        vecs[6]  = mk(0, 10, 0, 50, 0, 0, '0, '0);
        vecs[7]  = mk(1, 21, 31, 11, 0, 0, '0, '0);
        vecs[8]  = mk(1, 10, 32, 20, 0, 0, '0, '0);
        vecs[9]  = mk(0, 40, 0, 41, 0, 0, '0, '0);
        vecs[10] = mk(1, 11, 33, 21, 1, 2, pack_m(30, 32, 20, 10), pack_m(31, 33, 21, 11));
        vecs[11] = mk(1, 1, 2, 3, 1, 0, '0, '0);
        vecs[12] = mk(1, 2, 2, 1, 0, 0, '0, '0);
        vecs[13] = mk(1, 1, 5, 2, 1, 0, '0, '0);

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_nor_count", nor_count, 0);
        check("rst_m_data", {m_s, m_r, m_q, m_p}, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            cur_recs.push_back(mkrec(vecs[v].is_nor, vecs[v].a, vecs[v].b, vecs[v].y));
            if (vecs[v].last) begin
                if (vecs[v].n_exp > 0) exp_q.push_back(vecs[v].exp0);
                if (vecs[v].n_exp > 1) exp_q.push_back(vecs[v].exp1);
                run_cur();
            end
        end

        // Backpressure: minimal latch with m_ready low for 5 cycles.
        stall_mode = 5;
        cur_recs.push_back(mkrec(1, 1, 3, 2));
        cur_recs.push_back(mkrec(1, 2, 4, 3));
        exp_q.push_back(pack_m(1, 4, 3, 2));
        run_cur();
        stall_mode = 0;

        // Reset while a match is pending.
        cur_recs.push_back(mkrec(1, 1, 3, 2));
        cur_recs.push_back(mkrec(1, 2, 4, 3));
        send_recs();
        m_ready = 1'b0;
        w = 0;
        while (!m_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("pre_rst_m_valid", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_m_data", {m_s, m_r, m_q, m_p}, 0);
        check("mid_rst_count", nor_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_recs.delete();
        cur_recs.push_back(mkrec(1, 1, 3, 2));
        cur_recs.push_back(mkrec(1, 2, 4, 3));
        exp_q.push_back(pack_m(1, 4, 3, 2));
        run_cur();

        // Overflow: DEPTH+1 unrelated NORs.
        for (int k = 0; k <= DEPTH; k++)
            cur_recs.push_back(mkrec(1, 8'(k + 40), 8'(k + 80), 8'(k + 120)));
        model_matches();
        run_cur();

        // Randomized netlists over a small net-id space so latches occur often.
        stall_mode = -1;
        for (int t = 0; t < 30; t++) begin
            int n_nor;
            n_nor = (t == 29) ? 18 : int'($urandom_range(0, 7));
            for (int k = 0; k < n_nor; k++) begin
                if ($urandom_range(0, 2) == 0)
                    cur_recs.push_back(mkrec(0, 8'($urandom_range(1, 6)), 8'd0, 8'($urandom_range(1, 6))));
                cur_recs.push_back(mkrec(1, 8'($urandom_range(1, 6)), 8'($urandom_range(1, 6)),
                                         8'($urandom_range(1, 6))));
            end
            if (cur_recs.size() == 0) cur_recs.push_back(mkrec(0, 8'd1, 8'd0, 8'd2));
            model_matches();
            run_cur();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
